vga_timing_controller: RTL
==========================

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48, horizontal porch/sync widths in clocks; line total is 800.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT 10, V_SYNC 2, V_BACK 33, vertical porch/sync widths in lines; frame total is 525.
REQ-005 SHALL have port vga_clock, input, 1, the single clock (pixel rate).
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1, counter advance enable.
REQ-008 SHALL have ports h_sync and v_sync, output, 1 each, active-low sync pulses.
REQ-009 SHALL have ports column and row, output, int (32-bit signed), current pixel position.
REQ-010 SHALL have port display_enable, output, 1, high inside the visible area.
REQ-011 SHALL have ports frame_start and vblank, output, 1 each, frame-origin pulse and vertical-blank flag.
REQ-012 SHALL have ports mario_x_in, mario_y_in, goomba_x_in, goomba_y_in, input, int each, game-side positions.
REQ-013 SHALL have ports mario_x, mario_y, goomba_x, goomba_y, output, int each, frame-stable positions for the drawer.
REQ-014 SHALL have ports upd_req, input, 1, and upd_ack, output, 1, position-update handshake.

Function
REQ-015 SHALL hold the column counter in 0..799 and the row counter in 0..524, output directly as column and row.
REQ-016 SHALL, on each enable=1 cycle, increment column; at 799 column wraps to 0 and row increments; at row 524 with column 799, both wrap to 0.
REQ-017 SHALL hold both counters, and the sync outputs and display_enable, unchanged while enable=0.
REQ-018 SHALL decode display_enable = (column<640 && row<480) combinationally from the counter registers, giving zero latency relative to row/column.
REQ-019 SHALL drive h_sync low exactly for column 656..751 and v_sync low exactly for row 490..491; both are high otherwise.
REQ-020 SHALL drive vblank high exactly for row>=480.
REQ-021 SHALL pulse frame_start high for one cycle when row=0, column=0 and enable=1; it is 0 otherwise.
REQ-022 SHALL track the horizontal phase with a four-state machine H_ACTIVE (0..639), H_FRONT (640..655), H_SYNC (656..751), H_BACK (752..799); the phase always matches the column range.
REQ-023 SHALL latch all four *_in values into the position outputs on the first cycle with vblank=1, upd_req=1 and no update yet accepted in the current frame, and pulse upd_ack for that same cycle.
REQ-024 SHALL accept at most one update per frame; the per-frame flag clears on frame_start.
REQ-025 SHALL keep the position outputs constant when upd_req is low or vblank is 0, so the drawer never sees a mid-frame change.
REQ-026 SHALL hold a request raised during the visible area pending, without ack, until the next vblank; the requester holds *_in stable until ack.
REQ-027 SHALL NOT issue upd_ack while enable=0.

Reset
REQ-028 SHALL, while reset=1 at a vga_clock edge, clear row, column, position outputs and the per-frame flag to 0 and the phase to H_ACTIVE.
REQ-029 SHALL force display_enable=0, frame_start=0, vblank=0, upd_ack=0, h_sync=1 and v_sync=1 while reset=1, overriding decode.
REQ-030 SHALL, on the first enabled cycle after reset release, present row=0, column=0, display_enable=1, frame_start=1.
REQ-031 SHALL abandon a pending request on reset mid-frame without ack; the request re-arbitrates in the next vblank.

Configuration
REQ-032 SHALL, with VGA_TIMING_POS_LATCH_EN defined, implement the vblank-latched positions and handshake of REQ-023..REQ-027.
REQ-033 SHALL, without VGA_TIMING_POS_LATCH_EN, pass *_in combinationally to the position outputs and drive upd_ack = upd_req; no latch registers exist.

Verification
REQ-034 Reset, then enable=1 for 420000 cycles -> frame_start every 420000 cycles, first on cycle 0; h_sync low 96 cycles per 800.
REQ-035 Scan a full frame -> display_enable count 307200; v_sync low 1600 cycles; vblank high 36000 cycles.
REQ-036 upd_req=1 with mario_x_in=100 at row 200 -> mario_x stays 0 until row 480 column 0; there mario_x=100 with a single upd_ack pulse.
REQ-037 upd_req held high across two frames, inputs 5 then 9 -> exactly one ack per frame; outputs 5 then 9.
REQ-038 enable=0 for 50 cycles at column 700 -> column stays 700, h_sync stays 0, no frame_start or upd_ack.
REQ-039 reset=1 asserted at row 300 with upd_req pending -> row=column=0, positions 0, no ack; release -> frame_start on first cycle.

Source files
------------

// File: rtl/vga_timing_controller_if.sv
// Position-update bus between the game logic (master) and the VGA timing controller (slave).
interface vga_timing_controller_if;
    int   mario_x_in;
    int   mario_y_in;
    int   goomba_x_in;
    int   goomba_y_in;
    int   mario_x;
    int   mario_y;
    int   goomba_x;
    int   goomba_y;
    logic upd_req;
    logic upd_ack;

    modport master (
        output mario_x_in, mario_y_in, goomba_x_in, goomba_y_in, upd_req,
        input  mario_x, mario_y, goomba_x, goomba_y, upd_ack
    );

    modport slave (
        input  mario_x_in, mario_y_in, goomba_x_in, goomba_y_in, upd_req,
        output mario_x, mario_y, goomba_x, goomba_y, upd_ack
    );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator with a frame-stable sprite position hand-off.
// Define VGA_TIMING_POS_LATCH_EN to latch positions once per vertical blank; otherwise they pass straight through.
module vga_timing_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic enable,
    output logic h_sync,
    output logic v_sync,
    output int   column,
    output int   row,
    output logic display_enable,
    output logic frame_start,
    output logic vblank,
    vga_timing_controller_if.slave pos
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] H_FP_END   = HW'(H_VISIBLE + H_FRONT - 1);
    localparam logic [HW-1:0] H_SY_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_LIM  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_LIM  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SY_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SY_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    // PH_* rather than H_* so the state names do not collide with the width parameters
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } h_phase_t;

    logic [HW-1:0] col_r;
    logic [VW-1:0] row_r;
    h_phase_t      phase_r;

    // Raster counters: column wraps every line, row wraps every frame
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            col_r <= {HW{1'b0}};
            row_r <= {VW{1'b0}};
        end else if (enable) begin
            if (col_r == H_LAST) begin
                col_r <= {HW{1'b0}};
                if (row_r == V_LAST) begin
                    row_r <= {VW{1'b0}};
                end else begin
                    row_r <= row_r + {{(VW-1){1'b0}}, 1'b1};
                end
            end else begin
                col_r <= col_r + {{(HW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Horizontal phase machine, stepping at the last column of each phase
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            phase_r <= PH_ACTIVE;
        end else if (enable) begin
            case (phase_r)
                PH_ACTIVE: if (col_r == H_ACT_END) phase_r <= PH_FRONT;
                PH_FRONT:  if (col_r == H_FP_END)  phase_r <= PH_SYNC;
                PH_SYNC:   if (col_r == H_SY_END)  phase_r <= PH_BACK;
                PH_BACK:   if (col_r == H_LAST)    phase_r <= PH_ACTIVE;
                default:   phase_r <= PH_ACTIVE;
            endcase
        end
    end

    assign column = int'(col_r);
    assign row    = int'(row_r);

    // Zero-latency decode of the counter registers; reset forces the idle levels
    always_comb begin
        display_enable = 1'b0;
        h_sync         = 1'b1;
        v_sync         = 1'b1;
        vblank         = 1'b0;
        frame_start    = 1'b0;
        if (reset) begin
            display_enable = 1'b0;
        end else begin
            display_enable = (col_r < H_VIS_LIM) && (row_r < V_VIS_LIM);
            h_sync         = (phase_r != PH_SYNC);
            v_sync         = !((row_r >= V_SY_FIRST) && (row_r <= V_SY_LAST));
            vblank         = (row_r >= V_VIS_LIM);
            frame_start    = enable && (col_r == {HW{1'b0}}) && (row_r == {VW{1'b0}});
        end
    end

`ifdef VGA_TIMING_POS_LATCH_EN
    logic taken_r;
    logic ack_s;
    int   mario_x_r;
    int   mario_y_r;
    int   goomba_x_r;
    int   goomba_y_r;

    // At most one accepted update per frame, and only while the beam is in vertical blank
    always_comb begin
        ack_s = 1'b0;
        if (!reset && enable && vblank && pos.upd_req && !taken_r) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
    end

    // Position latches and the per-frame accepted flag
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            taken_r    <= 1'b0;
            mario_x_r  <= 32'sd0;
            mario_y_r  <= 32'sd0;
            goomba_x_r <= 32'sd0;
            goomba_y_r <= 32'sd0;
        end else if (ack_s) begin
            taken_r    <= 1'b1;
            mario_x_r  <= pos.mario_x_in;
            mario_y_r  <= pos.mario_y_in;
            goomba_x_r <= pos.goomba_x_in;
            goomba_y_r <= pos.goomba_y_in;
        end else if (frame_start) begin
            taken_r <= 1'b0;
        end
    end

    // The accepted values are already visible in the acknowledging cycle
    always_comb begin
        pos.upd_ack = ack_s;
        if (ack_s) begin
            pos.mario_x  = pos.mario_x_in;
            pos.mario_y  = pos.mario_y_in;
            pos.goomba_x = pos.goomba_x_in;
            pos.goomba_y = pos.goomba_y_in;
        end else begin
            pos.mario_x  = mario_x_r;
            pos.mario_y  = mario_y_r;
            pos.goomba_x = goomba_x_r;
            pos.goomba_y = goomba_y_r;
        end
    end
`else
    // Pass-through: positions and handshake follow the game side directly
    always_comb begin
        pos.mario_x  = pos.mario_x_in;
        pos.mario_y  = pos.mario_y_in;
        pos.goomba_x = pos.goomba_x_in;
        pos.goomba_y = pos.goomba_y_in;
        if (reset) begin
            pos.upd_ack = 1'b0;
        end else begin
            pos.upd_ack = pos.upd_req;
        end
    end
`endif

endmodule
